segdigits_to_bin: RTL and testbench



---
 rtl/segdigits_to_bin_pkg.sv | 44 ++++
 rtl/segdigits_to_bin_seg7_to_digit.sv | 28 ++
 rtl/segdigits_to_bin.sv | 132 +++++++++++++
 tb/tb_segdigits_to_bin.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segdigits_to_bin_pkg.sv
// Shared widths, seven-segment digit constants, FSM states and helpers for segdigits_to_bin.
package segdigits_to_bin_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BIN_W      = 7;
    localparam int unsigned TMP_W      = 11;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned MAX_DIGITS = 3;
    localparam int unsigned MAX_VALUE  = 127;

    // Segment patterns, bit 6 = a ... bit 0 = g (same order as the binary-to-display decoder)
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_ONE   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_TWO   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_THREE = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_FOUR  = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_FIVE  = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_SIX   = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_SEVEN = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_EIGHT = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_NINE  = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_MUL   = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Decoded digit payload from the segment decoder
    typedef struct packed {
        logic               invalid;
        logic [DIGIT_W-1:0] value;
    } seg_digit_t;

    // acc * 10 built from two shifts so no multiplier is inferred
    function automatic logic [TMP_W-1:0] times_ten(input logic [BIN_W-1:0] a);
        return (TMP_W'(a) << 3) + (TMP_W'(a) << 1);
    endfunction

endpackage

// File: rtl/segdigits_to_bin_seg7_to_digit.sv
// Combinational seven-segment pattern to decimal digit decoder with invalid flag.
module seg7_to_digit
    import segdigits_to_bin_pkg::*;
(
    input  logic [SEG_W-1:0] segments,
    output seg_digit_t       decoded_c
);

    // Exact match against the ten legal patterns; anything else is invalid
    always_comb begin
        decoded_c.value   = '0;
        decoded_c.invalid = 1'b0;
        case (segments)
            SEG_ZERO:  decoded_c.value = DIGIT_W'(0);
            SEG_ONE:   decoded_c.value = DIGIT_W'(1);
            SEG_TWO:   decoded_c.value = DIGIT_W'(2);
            SEG_THREE: decoded_c.value = DIGIT_W'(3);
            SEG_FOUR:  decoded_c.value = DIGIT_W'(4);
            SEG_FIVE:  decoded_c.value = DIGIT_W'(5);
            SEG_SIX:   decoded_c.value = DIGIT_W'(6);
            SEG_SEVEN: decoded_c.value = DIGIT_W'(7);
            SEG_EIGHT: decoded_c.value = DIGIT_W'(8);
            SEG_NINE:  decoded_c.value = DIGIT_W'(9);
            default:   decoded_c.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/segdigits_to_bin.sv
// Sequential decimal-entry decoder: up to three seven-segment digits, MSD first, into a 7-bit value.
module segdigits_to_bin
    import segdigits_to_bin_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [SEG_W-1:0] segments,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic             enter,
    input  logic             clear,
    output logic [BIN_W-1:0] bin,
    output logic             bin_valid,
    output logic             error,
    output logic [CNT_W-1:0] digit_count
);

    state_t               state, state_d;
    logic [BIN_W-1:0]     acc, acc_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [DIGIT_W-1:0]   digit, digit_d;
    logic [TMP_W-1:0]     tmp, tmp_d;

    logic [BIN_W-1:0]     bin_d;
    logic                 bin_valid_d;
    logic                 error_d;
    logic                 digit_ready_d;

    seg_digit_t           decoded_c;
    logic                 can_take_c;
    logic                 accept_c;
    logic [TMP_W-1:0]     sum_c;

    seg7_to_digit u_dec (
        .segments  (segments),
        .decoded_c (decoded_c)
    );

    // Handshake and datapath terms shared by the next-state logic
    always_comb begin
        can_take_c = (state == ST_IDLE) ||
                     ((state == ST_ENTRY) && (cnt < CNT_W'(MAX_DIGITS)));
        accept_c   = digit_valid && can_take_c;
        sum_c      = tmp + TMP_W'(digit);
    end

    // Next-state and next-output logic; clear beats digit acceptance beats enter
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        digit_d = digit;
        tmp_d   = tmp;

        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (accept_c) begin
                        if (decoded_c.invalid) begin
                            state_d = ST_ERR;
                        end else begin
                            digit_d = decoded_c.value;
                            state_d = ST_MUL;
                        end
                    end else if ((state == ST_ENTRY) && enter && (cnt != '0)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_MUL: begin
                    tmp_d   = times_ten(acc);
                    state_d = ST_ADD;
                end
                ST_ADD: begin
                    if (sum_c > TMP_W'(MAX_VALUE)) begin
                        state_d = ST_ERR;
                    end else begin
                        acc_d   = BIN_W'(sum_c);
                        cnt_d   = cnt + CNT_W'(1);
                        state_d = ST_ENTRY;
                    end
                end
                ST_DONE, ST_ERR: begin
                    state_d = state;
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so they land in registers
        bin_d         = (state_d == ST_ERR) ? '0 : acc_d;
        bin_valid_d   = (state_d == ST_DONE);
        error_d       = (state_d == ST_ERR);
        digit_ready_d = (state_d == ST_IDLE) ||
                        ((state_d == ST_ENTRY) && (cnt_d < CNT_W'(MAX_DIGITS)));
    end

    // State, datapath and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            cnt         <= '0;
            digit       <= '0;
            tmp         <= '0;
            bin         <= '0;
            bin_valid   <= 1'b0;
            error       <= 1'b0;
            digit_count <= '0;
            digit_ready <= 1'b1;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            cnt         <= cnt_d;
            digit       <= digit_d;
            tmp         <= tmp_d;
            bin         <= bin_d;
            bin_valid   <= bin_valid_d;
            error       <= error_d;
            digit_count <= cnt_d;
            digit_ready <= digit_ready_d;
        end
    end

endmodule

// File: tb/tb_segdigits_to_bin.sv
// Self-checking bench for segdigits_to_bin: directed scenarios plus randomized entries vs a decimal model.
module tb_segdigits_to_bin;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [6:0] segments;
    logic       digit_valid;
    logic       digit_ready;
    logic       enter;
    logic       clear;
    logic [6:0] bin;
    logic       bin_valid;
    logic       error;
    logic [1:0] digit_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] legal [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b0011111, 7'b1110000, 7'b1111111, 7'b1110011};

    segdigits_to_bin dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .segments    (segments),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .enter       (enter),
        .clear       (clear),
        .bin         (bin),
        .bin_valid   (bin_valid),
        .error       (error),
        .digit_count (digit_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Decimal meaning of a pattern, -1 when it is not a digit
    function automatic int model_val(input logic [6:0] s);
        for (int i = 0; i < 10; i++)
            if (legal[i] == s) return i;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for digit_ready, then present one digit for a single cycle
    task automatic send_digit(input logic [6:0] seg, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (digit_ready) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        if (!timeout) begin
            segments    = seg;
            digit_valid = 1'b1;
            tick();
            digit_valid = 1'b0;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; segments = '0; digit_valid = 1'b0; enter = 1'b0; clear = 1'b0;
        #12;
        n_cmp++; if (bin !== 7'd0) begin n_bad++; $display("FAIL reset_bin got=%0d exp=0", bin); end
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL reset_bin_valid got=%b exp=0", bin_valid); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b exp=0", error); end
        n_cmp++; if (digit_count !== 2'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
        n_cmp++; if (digit_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", digit_ready); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_127();
        bit to;
        int gap;
        logic [6:0] seq [3] = '{legal[1], legal[2], legal[7]};
        for (int k = 0; k < 3; k++) begin
            send_digit(seq[k], to);
            n_cmp++; if (to) begin n_bad++; $display("FAIL d127_ready_timeout digit=%0d", k); end
            if (k < 2) begin
                gap = 0;
                for (int i = 0; i < 10; i++) begin
                    if (digit_ready) break;
                    gap++;
                    tick();
                end
                n_cmp++; if (gap != 2) begin n_bad++; $display("FAIL d127_gap got=%0d exp=2", gap); end
            end else begin
                tick(); tick();
            end
        end
        n_cmp++; if (digit_ready !== 1'b0) begin n_bad++; $display("FAIL d127_full_ready got=%b exp=0", digit_ready); end
        pulse_enter();
        n_cmp++; if (bin !== 7'd127) begin n_bad++; $display("FAIL d127_bin got=%0d exp=127", bin); end
        n_cmp++; if (bin_valid !== 1'b1) begin n_bad++; $display("FAIL d127_valid got=%b exp=1", bin_valid); end
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL d127_error got=%b exp=0", error); end
        n_cmp++; if (digit_count !== 2'd3) begin n_bad++; $display("FAIL d127_count got=%0d exp=3", digit_count); end
        tick();
        n_cmp++; if (bin_valid !== 1'b1) begin n_bad++; $display("FAIL d127_hold got=%b exp=1", bin_valid); end
        pulse_clear();
    endtask

    task automatic test_overflow();
        bit to;
        send_digit(legal[1], to);
        send_digit(legal[2], to);
        send_digit(legal[8], to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL ovf_ready_timeout"); end
        tick();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL ovf_early_error got=%b exp=0", error); end
        tick();
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ovf_error got=%b exp=1", error); end
        n_cmp++; if (bin !== 7'd0) begin n_bad++; $display("FAIL ovf_bin got=%0d exp=0", bin); end
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_valid got=%b exp=0", bin_valid); end
        pulse_clear();
        n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_error got=%b exp=0", error); end
        n_cmp++; if (digit_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_clear_ready got=%b exp=1", digit_ready); end
        n_cmp++; if (digit_count !== 2'd0) begin n_bad++; $display("FAIL ovf_clear_count got=%0d exp=0", digit_count); end
    endtask

    task automatic test_invalid();
        bit to;
        send_digit(7'b0000001, to);
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL inv_error got=%b exp=1", error); end
        n_cmp++; if (digit_ready !== 1'b0) begin n_bad++; $display("FAIL inv_ready got=%b exp=0", digit_ready); end
        pulse_enter();
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL inv_enter_valid got=%b exp=0", bin_valid); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL inv_sticky got=%b exp=1", error); end
        pulse_clear();
    endtask

    task automatic test_enter_zero();
        bit to;
        pulse_enter();
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL ez_valid got=%b exp=0", bin_valid); end
        n_cmp++; if (digit_ready !== 1'b1) begin n_bad++; $display("FAIL ez_ready got=%b exp=1", digit_ready); end
        send_digit(legal[0], to);
        tick(); tick();
        pulse_enter();
        n_cmp++; if (bin !== 7'd0) begin n_bad++; $display("FAIL ez_bin got=%0d exp=0", bin); end
        n_cmp++; if (bin_valid !== 1'b1) begin n_bad++; $display("FAIL ez_done got=%b exp=1", bin_valid); end
        n_cmp++; if (digit_count !== 2'd1) begin n_bad++; $display("FAIL ez_count got=%0d exp=1", digit_count); end
        pulse_clear();
    endtask

    task automatic test_hold9();
        int taken = 0;
        segments    = legal[9];
        digit_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (digit_ready) taken++;
            tick();
        end
        digit_valid = 1'b0;
        n_cmp++; if (taken != 3) begin n_bad++; $display("FAIL hold9_taken got=%0d exp=3", taken); end
        n_cmp++; if (digit_ready !== 1'b0) begin n_bad++; $display("FAIL hold9_ready got=%b exp=0", digit_ready); end
        n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL hold9_error got=%b exp=1", error); end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        bit to;
        send_digit(legal[1], to);
        tick(); tick();
        segments    = legal[2];
        digit_valid = 1'b1;
        enter       = 1'b1;
        tick();
        digit_valid = 1'b0;
        enter       = 1'b0;
        n_cmp++; if (bin_valid !== 1'b0) begin n_bad++; $display("FAIL same_valid got=%b exp=0", bin_valid); end
        tick(); tick();
        n_cmp++; if (digit_count !== 2'd2) begin n_bad++; $display("FAIL same_count got=%0d exp=2", digit_count); end
        n_cmp++; if (bin !== 7'd12) begin n_bad++; $display("FAIL same_acc got=%0d exp=12", bin); end
        pulse_enter();
        n_cmp++; if (bin_valid !== 1'b1 || bin !== 7'd12) begin n_bad++; $display("FAIL same_done got=%b/%0d exp=1/12", bin_valid, bin); end
        pulse_clear();
    endtask

    task automatic test_reset_mid();
        bit to;
        send_digit(legal[5], to);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (digit_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got=%b exp=1", digit_ready); end
        n_cmp++; if (bin !== 7'd0 || bin_valid !== 1'b0 || error !== 1'b0 || digit_count !== 2'd0) begin
            n_bad++; $display("FAIL rmid_outputs got=%0d/%b/%b/%0d exp=0/0/0/0", bin, bin_valid, error, digit_count);
        end
        tick();
        reset_n = 1'b1;
        send_digit(legal[4], to);
        tick(); tick();
        pulse_enter();
        n_cmp++; if (bin !== 7'd4 || bin_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_entry got=%0d/%b exp=4/1", bin, bin_valid); end
        pulse_clear();
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 40; it++) begin
            int n    = int'($urandom_range(1, 3));
            int acc  = 0;
            int sent = 0;
            bit err  = 1'b0;
            for (int k = 0; k < n; k++) begin
                logic [6:0] seg;
                int v;
                if ($urandom_range(0, 7) == 0) begin
                    seg = 7'($urandom);
                    while (model_val(seg) >= 0) seg = 7'($urandom);
                end else begin
                    seg = legal[$urandom_range(0, 9)];
                end
                send_digit(seg, to);
                n_cmp++; if (to) begin n_bad++; $display("FAIL rnd_ready_timeout it=%0d k=%0d", it, k); end
                sent++;
                v = model_val(seg);
                if (v < 0) begin err = 1'b1; break; end
                acc = acc * 10 + v;
                if (acc > 127) begin err = 1'b1; break; end
            end
            tick(); tick();
            if (!err) begin
                pulse_enter();
                n_cmp++; if (bin_valid !== 1'b1 || bin !== 7'(acc) || error !== 1'b0 || digit_count !== 2'(sent)) begin
                    n_bad++; $display("FAIL rnd_done it=%0d got=%b/%0d/%b/%0d exp=1/%0d/0/%0d", it, bin_valid, bin, error, digit_count, acc, sent);
                end
            end else begin
                n_cmp++; if (error !== 1'b1 || bin !== 7'd0 || bin_valid !== 1'b0 || digit_ready !== 1'b0) begin
                    n_bad++; $display("FAIL rnd_err it=%0d got=%b/%0d/%b/%b exp=1/0/0/0", it, error, bin, bin_valid, digit_ready);
                end
            end
            pulse_clear();
            n_cmp++; if (digit_ready !== 1'b1 || error !== 1'b0 || bin_valid !== 1'b0) begin
                n_bad++; $display("FAIL rnd_clear it=%0d got=%b/%b/%b exp=1/0/0", it, digit_ready, error, bin_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_127();
        test_overflow();
        test_invalid();
        test_enter_zero();
        test_hold9();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
